// File: rtl/serial_sub_pkg.sv
// serial_sub shared types: FSM state encoding and default operand width.
// Optional signed-overflow output is enabled by SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_if.sv
// start/done handshake and operand/result bus for serial_sub.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_sub_fs.sv
// Combinational full-subtractor cell: d = a - b - bin, bout = borrow out.
// Shared by serial_sub (SERIAL_SUB_OVF_EN does not affect this cell).
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH clocks.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             d, bout, last;

  fs u_fs (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (borrow_q),
    .d   (d),
    .bout(bout)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d   = {d, diff_q[WIDTH-1:1]};
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = bout;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          // a_q[0]/b_q[0] hold the operand MSBs on the final bit
          ovf_d   = (a_q[0] != b_q[0]) && (d != a_q[0]);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8), random + directed.
// ovf is checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  task automatic check_result(input logic [7:0] a, input logic [7:0] b);
    int ea, eb, sr;
    logic [7:0] ed;
    ea = int'(a);
    eb = int'(b);
    ed = 8'((ea - eb + 256) % 256);
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("borrow", 32'(bus.borrow), (ea < eb) ? 1 : 0);
    sr = int'($signed(a)) - int'($signed(b));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(bus.ovf), (sr > 127 || sr < -128) ? 1 : 0);
`else
    if (sr > 1000) $display("unexpected signed range %0d", sr);
`endif
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    int lat;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    lat = 1;
    chk("busy_on", 32'(bus.busy), 1);
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), W + 1);
    chk("busy_at_done", 32'(bus.busy), 0);
    check_result(a, b);
    @(negedge clk);
    chk("done_single", 32'(bus.done), 0);
    check_result(a, b);
  endtask

  initial begin
    logic [7:0] da [6];
    logic [7:0] db [6];
    int pulses, prev;
    n_tests = 0;
    n_fail  = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_diff", 32'(bus.diff), 0);
    chk("rst_borrow", 32'(bus.borrow), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    da = '{8'd5, 8'd3, 8'h80, 8'h00, 8'hFF, 8'h7F};
    db = '{8'd3, 8'd5, 8'h01, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 6; i++) run_op(da[i], db[i]);

    // start during RUN must be ignored
    bus.a = 8'h10;
    bus.b = 8'h01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      if (bus.done) pulses++;
      @(negedge clk);
    end
    chk("ign_pulses", 32'(pulses), 1);
    chk("ign_diff", 32'(bus.diff), 32'h0F);
    chk("ign_borrow", 32'(bus.borrow), 0);

    // reset mid-RUN
    bus.a = 8'hAB;
    bus.b = 8'h12;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_diff", 32'(bus.diff), 0);
    chk("mid_rst_borrow", 32'(bus.borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("mid_rst_ovf", 32'(bus.ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'd9, 8'd9);

    // back-to-back with start held high
    bus.a = 8'h00;
    bus.b = 8'h01;
    bus.start = 1'b1;
    pulses = 0;
    prev = -1;
    for (int c = 1; c < 45; c++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (prev < 0) chk("b2b_first", 32'(c), W + 1);
        else chk("b2b_gap", 32'(c - prev), W + 2);
        prev = c;
        chk("b2b_busy", 32'(bus.busy), 0);
        chk("b2b_diff", 32'(bus.diff), 32'hFF);
        chk("b2b_borrow", 32'(bus.borrow), 1);
      end
    end
    chk("b2b_pulses", 32'(pulses), 4);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
